ddr3_wb_arbiter: RTL and testbench

- Two-port round-robin Wishbone (pipelined) arbiter in front of the single user Wishbone port of ddr3_top.
- Lets two independent masters (e.g. UART command path and a memory-test engine) share the controller.
- Keeps an in-order FIFO of requester IDs for accepted requests, so each ack and its read data return to the requester that issued the request.
- Handles requester bus aborts without aborting the other requester's outstanding transactions.

---
 rtl/ddr3_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr3_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wb_arbiter.sv
// Two-port round-robin pipelined-Wishbone arbiter in front of the ddr3_top user port; 0-cycle request and ack paths.
// Backpressure: a requester is stalled unless granted, and always while the controller stalls or the ID FIFO is full.
module ddr3_wb_arbiter #(
    parameter int ADDR_BITS   = 24,
    parameter int DATA_BITS   = 128,
    parameter int SEL_BITS    = DATA_BITS / 8,
    parameter int MAX_PENDING = 8
) (
    input  logic                           i_controller_clk,
    input  logic                           i_rst_n,
    input  logic                           i_wb0_cyc,
    input  logic                           i_wb0_stb,
    input  logic                           i_wb0_we,
    input  logic [ADDR_BITS-1:0]           i_wb0_addr,
    input  logic [DATA_BITS-1:0]           i_wb0_data,
    input  logic [SEL_BITS-1:0]            i_wb0_sel,
    output logic                           o_wb0_stall,
    output logic                           o_wb0_ack,
    output logic [DATA_BITS-1:0]           o_wb0_data,
    input  logic                           i_wb1_cyc,
    input  logic                           i_wb1_stb,
    input  logic                           i_wb1_we,
    input  logic [ADDR_BITS-1:0]           i_wb1_addr,
    input  logic [DATA_BITS-1:0]           i_wb1_data,
    input  logic [SEL_BITS-1:0]            i_wb1_sel,
    output logic                           o_wb1_stall,
    output logic                           o_wb1_ack,
    output logic [DATA_BITS-1:0]           o_wb1_data,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic                           o_wb_we,
    output logic [ADDR_BITS-1:0]           o_wb_addr,
    output logic [DATA_BITS-1:0]           o_wb_data,
    output logic [SEL_BITS-1:0]            o_wb_sel,
    input  logic                           i_wb_stall,
    input  logic                           i_wb_ack,
    input  logic [DATA_BITS-1:0]           i_wb_data,
    output logic [$clog2(MAX_PENDING):0]   o_pending,
    output logic                           o_err_unexp_ack
);

    localparam int PTR_BITS = $clog2(MAX_PENDING);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(MAX_PENDING);

    logic [MAX_PENDING-1:0] r_id;
    logic [MAX_PENDING-1:0] r_live;
    logic [PTR_BITS-1:0]    r_wr_ptr;
    logic [PTR_BITS-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0]    r_count;
    logic                   r_prio;
    logic                   r_err;
    logic                   r_we;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_data;
    logic [SEL_BITS-1:0]    r_sel;
    logic [DATA_BITS-1:0]   r_wb0_data;
    logic [DATA_BITS-1:0]   r_wb1_data;

    logic w_req0, w_req1, w_gnt_vld, w_gnt_id;
    logic w_full, w_empty, w_stb, w_push, w_pop;
    logic w_head_id, w_head_live, w_ack0, w_ack1;
    logic                 w_fwd_we;
    logic [ADDR_BITS-1:0] w_fwd_addr;
    logic [DATA_BITS-1:0] w_fwd_data;
    logic [SEL_BITS-1:0]  w_fwd_sel;

    assign w_req0    = i_wb0_cyc & i_wb0_stb;
    assign w_req1    = i_wb1_cyc & i_wb1_stb;
    assign w_gnt_vld = w_req0 | w_req1;
    assign w_gnt_id  = (w_req0 & w_req1) ? r_prio : w_req1;

    // Full is taken from the registered count only, so a same-cycle pop never lets a push through.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_stb   = w_gnt_vld & ~w_full;
    assign w_push  = w_stb & ~i_wb_stall;
    assign w_pop   = i_wb_ack & ~w_empty;

    // A requester dropping cyc in the ack cycle loses that ack too, not just later ones.
    assign w_head_id   = r_id[r_rd_ptr];
    assign w_head_live = r_live[r_rd_ptr] & (w_head_id ? i_wb1_cyc : i_wb0_cyc);
    assign w_ack0      = w_pop & w_head_live & ~w_head_id;
    assign w_ack1      = w_pop & w_head_live & w_head_id;

    assign w_fwd_we   = w_gnt_id ? i_wb1_we   : i_wb0_we;
    assign w_fwd_addr = w_gnt_id ? i_wb1_addr : i_wb0_addr;
    assign w_fwd_data = w_gnt_id ? i_wb1_data : i_wb0_data;
    assign w_fwd_sel  = w_gnt_id ? i_wb1_sel  : i_wb0_sel;

    assign o_wb_we   = w_gnt_vld ? w_fwd_we   : r_we;
    assign o_wb_addr = w_gnt_vld ? w_fwd_addr : r_addr;
    assign o_wb_data = w_gnt_vld ? w_fwd_data : r_data;
    assign o_wb_sel  = w_gnt_vld ? w_fwd_sel  : r_sel;

    // Control outputs are forced to their idle values for as long as reset is held.
    assign o_wb_stb    = i_rst_n & w_stb;
    assign o_wb_cyc    = i_rst_n & (i_wb0_cyc | i_wb1_cyc | ~w_empty);
    assign o_wb0_stall = ~i_rst_n | ~(w_gnt_vld & ~w_gnt_id) | i_wb_stall | w_full;
    assign o_wb1_stall = ~i_rst_n | ~(w_gnt_vld & w_gnt_id) | i_wb_stall | w_full;
    assign o_wb0_ack   = i_rst_n & w_ack0;
    assign o_wb1_ack   = i_rst_n & w_ack1;
    assign o_wb0_data  = w_ack0 ? i_wb_data : r_wb0_data;
    assign o_wb1_data  = w_ack1 ? i_wb_data : r_wb1_data;

    assign o_pending       = r_count;
    assign o_err_unexp_ack = r_err;

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id       <= '0;
            r_live     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_prio     <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_sel      <= '0;
            r_wb0_data <= '0;
            r_wb1_data <= '0;
        end else begin
            // Aborted entries stay queued so the controller's acks are still consumed.
            for (int i = 0; i < MAX_PENDING; i++) begin
                if ((!r_id[i] && !i_wb0_cyc) || (r_id[i] && !i_wb1_cyc))
                    r_live[i] <= 1'b0;
            end
            if (w_push) begin
                r_id[r_wr_ptr]   <= w_gnt_id;
                r_live[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + PTR_BITS'(1);
                r_prio           <= ~w_gnt_id;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_BITS'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_BITS'(1);
            if (i_wb_ack && w_empty)
                r_err <= 1'b1;
            if (w_gnt_vld) begin
                r_we   <= w_fwd_we;
                r_addr <= w_fwd_addr;
                r_data <= w_fwd_data;
                r_sel  <= w_fwd_sel;
            end
            if (w_ack0)
                r_wb0_data <= i_wb_data;
            if (w_ack1)
                r_wb1_data <= i_wb_data;
        end
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed bench for ddr3_wb_arbiter: inputs change 1ns after posedge, outputs are checked on the negedge.
module tb_ddr3_wb_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb0_cyc, wb0_stb, wb0_we;
    logic [23:0]   wb0_addr;
    logic [127:0]  wb0_wdat;
    logic [15:0]   wb0_sel;
    logic          wb0_stall, wb0_ack;
    logic [127:0]  wb0_rdat;
    logic          wb1_cyc, wb1_stb, wb1_we;
    logic [23:0]   wb1_addr;
    logic [127:0]  wb1_wdat;
    logic [15:0]   wb1_sel;
    logic          wb1_stall, wb1_ack;
    logic [127:0]  wb1_rdat;
    logic          wb_cyc, wb_stb, wb_we;
    logic [23:0]   wb_addr;
    logic [127:0]  wb_wdat;
    logic [15:0]   wb_sel;
    logic          wb_stall, wb_ack;
    logic [127:0]  wb_rdat;
    logic [3:0]    pending;
    logic          err_unexp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ddr3_wb_arbiter dut (
        .i_controller_clk (clk),
        .i_rst_n          (rst_n),
        .i_wb0_cyc        (wb0_cyc),
        .i_wb0_stb        (wb0_stb),
        .i_wb0_we         (wb0_we),
        .i_wb0_addr       (wb0_addr),
        .i_wb0_data       (wb0_wdat),
        .i_wb0_sel        (wb0_sel),
        .o_wb0_stall      (wb0_stall),
        .o_wb0_ack        (wb0_ack),
        .o_wb0_data       (wb0_rdat),
        .i_wb1_cyc        (wb1_cyc),
        .i_wb1_stb        (wb1_stb),
        .i_wb1_we         (wb1_we),
        .i_wb1_addr       (wb1_addr),
        .i_wb1_data       (wb1_wdat),
        .i_wb1_sel        (wb1_sel),
        .o_wb1_stall      (wb1_stall),
        .o_wb1_ack        (wb1_ack),
        .o_wb1_data       (wb1_rdat),
        .o_wb_cyc         (wb_cyc),
        .o_wb_stb         (wb_stb),
        .o_wb_we          (wb_we),
        .o_wb_addr        (wb_addr),
        .o_wb_data        (wb_wdat),
        .o_wb_sel         (wb_sel),
        .i_wb_stall       (wb_stall),
        .i_wb_ack         (wb_ack),
        .i_wb_data        (wb_rdat),
        .o_pending        (pending),
        .o_err_unexp_ack  (err_unexp)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        wb0_cyc = 1'b1; wb0_stb = 1'b1; wb0_we = 1'b0; wb0_addr = 24'h0; wb0_wdat = '0; wb0_sel = 16'hFFFF;
        wb1_cyc = 1'b0; wb1_stb = 1'b0; wb1_we = 1'b0; wb1_addr = 24'h0; wb1_wdat = '0; wb1_sel = 16'h00FF;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_rdat = '0;

        // Reset values while a request is pending on port 0
        sample();
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stall0", wb0_stall, 1'b1);
        chk("rst_stall1", wb1_stall, 1'b1);
        chk("rst_ack0", wb0_ack, 1'b0);
        chk("rst_pending", pending, 4'd0);
        chk("rst_err", err_unexp, 1'b0);
        tick();
        wb0_cyc = 1'b0; wb0_stb = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single requester: write 0x10 then read 0x10
        wb0_cyc = 1'b1; wb0_stb = 1'b1; wb0_we = 1'b1; wb0_addr = 24'h10; wb0_wdat = 128'hC0FFEE;
        sample();
        chk("s_stb", wb_stb, 1'b1);
        chk("s_addr", wb_addr, 24'h10);
        chk("s_we", wb_we, 1'b1);
        chk("s_wdat", wb_wdat, 128'hC0FFEE);
        chk("s_sel", wb_sel, 16'hFFFF);
        chk("s_stall0", wb0_stall, 1'b0);
        chk("s_stall1", wb1_stall, 1'b1);
        tick();
        wb0_we = 1'b0;
        sample();
        chk("s_pend1", pending, 4'd1);
        chk("s_we_rd", wb_we, 1'b0);
        tick();
        wb0_stb = 1'b0;
        sample();
        chk("s_pend2", pending, 4'd2);
        chk("s_idle_stb", wb_stb, 1'b0);
        chk("s_hold_addr", wb_addr, 24'h10);
        chk("s_hold_we", wb_we, 1'b0);
        chk("s_cyc", wb_cyc, 1'b1);
        tick();
        tick();
        wb_ack = 1'b1; wb_rdat = 128'hDEAD;
        sample();
        chk("s_ack0_w", wb0_ack, 1'b1);
        chk("s_ack1_w", wb1_ack, 1'b0);
        tick();
        wb_rdat = 128'h1234_5678_9ABC;
        sample();
        chk("s_ack0_r", wb0_ack, 1'b1);
        chk("s_ack1_r", wb1_ack, 1'b0);
        chk("s_rdat0", wb0_rdat, 128'h1234_5678_9ABC);
        tick();
        wb_ack = 1'b0; wb_rdat = 128'h0;
        sample();
        chk("s_pend0", pending, 4'd0);
        chk("s_noack", wb0_ack, 1'b0);
        chk("s_rdat_hold", wb0_rdat, 128'h1234_5678_9ABC);
        tick();
        wb0_cyc = 1'b0;
        sample();
        chk("s_cyc_off", wb_cyc, 1'b0);
        tick();

        // Contention from reset: strict alternation starting with port 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wb0_cyc = 1'b1; wb0_stb = 1'b1; wb0_addr = 24'h100;
        wb1_cyc = 1'b1; wb1_stb = 1'b1; wb1_addr = 24'h200;
        for (int k = 0; k < 6; k++) begin
            sample();
            chk($sformatf("c_addr%0d", k), wb_addr, (k % 2 == 1) ? 24'h200 : 24'h100);
            chk($sformatf("c_stall0_%0d", k), wb0_stall, (k % 2 == 1));
            chk($sformatf("c_stall1_%0d", k), wb1_stall, (k % 2 == 0));
            tick();
        end
        wb0_stb = 1'b0; wb1_stb = 1'b0;
        sample();
        chk("c_pend6", pending, 4'd6);
        tick();
        wb_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wb_rdat = 128'hA0 + 128'(k);
            sample();
            chk($sformatf("c_ack0_%0d", k), wb0_ack, (k % 2 == 0));
            chk($sformatf("c_ack1_%0d", k), wb1_ack, (k % 2 == 1));
            if (k % 2 == 0) chk($sformatf("c_rdat0_%0d", k), wb0_rdat, 128'hA0 + 128'(k));
            else            chk($sformatf("c_rdat1_%0d", k), wb1_rdat, 128'hA0 + 128'(k));
            tick();
        end
        wb_ack = 1'b0;
        sample();
        chk("c_pend0", pending, 4'd0);
        tick();

        // Controller stall holds the request on port 0
        wb1_cyc = 1'b0;
        wb0_stb = 1'b1; wb0_addr = 24'h55; wb0_wdat = 128'h77; wb_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk($sformatf("st_stall0_%0d", k), wb0_stall, 1'b1);
            chk($sformatf("st_addr_%0d", k), wb_addr, 24'h55);
            chk($sformatf("st_wdat_%0d", k), wb_wdat, 128'h77);
            chk($sformatf("st_pend_%0d", k), pending, 4'd0);
            tick();
        end
        wb_stall = 1'b0;
        sample();
        chk("st_release", wb0_stall, 1'b0);
        tick();
        wb0_stb = 1'b0;
        sample();
        chk("st_pend1", pending, 4'd1);
        tick();
        wb_ack = 1'b1;
        sample();
        chk("st_ack0", wb0_ack, 1'b1);
        tick();
        wb_ack = 1'b0;
        wb0_cyc = 1'b0;

        // Fill the FIFO from port 1, then ack-while-full
        wb1_cyc = 1'b1; wb1_stb = 1'b1; wb1_addr = 24'h300;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk($sformatf("f_stall1_%0d", k), wb1_stall, 1'b0);
            tick();
        end
        sample();
        chk("f_pend8", pending, 4'd8);
        chk("f_stall_full", wb1_stall, 1'b1);
        chk("f_stb_full", wb_stb, 1'b0);
        tick();
        wb_ack = 1'b1; wb_rdat = 128'hF0;
        sample();
        chk("f_ack1", wb1_ack, 1'b1);
        chk("f_stall_pop", wb1_stall, 1'b1);
        tick();
        wb_ack = 1'b0;
        sample();
        chk("f_pend7", pending, 4'd7);
        chk("f_stall_free", wb1_stall, 1'b0);
        tick();
        wb1_stb = 1'b0;
        sample();
        chk("f_pend8b", pending, 4'd8);
        tick();
        wb_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk($sformatf("f_drain_%0d", k), wb1_ack, 1'b1);
            tick();
        end
        wb_ack = 1'b0;
        sample();
        chk("f_pend0", pending, 4'd0);
        tick();

        // Abort: ids 0,1,0,1,0 queued, port 0 drops cyc in the first ack cycle
        wb0_cyc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb0_stb = (k % 2 == 0);
            wb1_stb = (k % 2 == 1);
            tick();
        end
        wb0_stb = 1'b0; wb1_stb = 1'b0;
        sample();
        chk("a_pend5", pending, 4'd5);
        tick();
        wb0_cyc = 1'b0; wb_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb_rdat = 128'hB0 + 128'(k);
            sample();
            chk($sformatf("a_ack0_%0d", k), wb0_ack, 1'b0);
            chk($sformatf("a_ack1_%0d", k), wb1_ack, (k % 2 == 1));
            chk($sformatf("a_cyc_%0d", k), wb_cyc, 1'b1);
            tick();
        end
        wb_ack = 1'b0;
        sample();
        chk("a_pend0", pending, 4'd0);
        chk("a_rdat1", wb1_rdat, 128'hB3);
        tick();
        wb1_cyc = 1'b0;
        sample();
        chk("a_cyc_off", wb_cyc, 1'b0);
        tick();

        // Unexpected ack with empty FIFO
        wb_ack = 1'b1;
        sample();
        chk("u_ack0", wb0_ack, 1'b0);
        chk("u_ack1", wb1_ack, 1'b0);
        chk("u_err_pre", err_unexp, 1'b0);
        tick();
        wb_ack = 1'b0;
        sample();
        chk("u_err", err_unexp, 1'b1);
        tick();
        sample();
        chk("u_err_sticky", err_unexp, 1'b1);
        tick();

        // Asynchronous reset mid-traffic
        wb0_cyc = 1'b1; wb0_stb = 1'b1;
        tick(); tick(); tick();
        sample();
        chk("r_pend3", pending, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("r_pend0", pending, 4'd0);
        chk("r_stb", wb_stb, 1'b0);
        chk("r_cyc", wb_cyc, 1'b0);
        chk("r_stall0", wb0_stall, 1'b1);
        chk("r_stall1", wb1_stall, 1'b1);
        chk("r_err", err_unexp, 1'b0);
        tick();
        wb0_cyc = 1'b0; wb0_stb = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
